pc_seq: RTL and testbench
=========================

# pc_seq

Parametrised program-counter sequencer for the simulator's instruction-fetch path. It replaces the fixed 12-bit increment-only counter with four operations: increment, absolute jump, subroutine call and return. It keeps a small return-address stack (RAS) with full, empty and error signalling. `pc_addr` drives the instruction-memory address port directly.

## Interface
Parameters:
- `ADDR_W`, default 12: address width in bits.
- `RAS_DEPTH`, default 4: number of return-address entries, at least 1.
- `RESET_ADDR`, default 0: value loaded into `pc_addr` on reset.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `enable`  in  1  advance strobe; low means hold all state.
- `jump`  in  1  load `jump_addr` into the PC.
- `jump_addr`  in  ADDR_W  target for `jump` and `call`.
- `call`  in  1  push return address, then branch to `jump_addr`.
- `ret`  in  1  pop return address into the PC.
- `pc_addr`  out  ADDR_W  current fetch address, registered.
- `ras_empty`  out  1  stack holds 0 entries.
- `ras_full`  out  1  stack holds `RAS_DEPTH` entries.
- `ras_err`  out  1  one-cycle pulse on overflow or underflow.

## Operation
Reset (`rst_n` = 0 at a rising edge):
- `pc_addr` = `RESET_ADDR`; stack count = 0.
- `ras_empty` = 1, `ras_full` = 0, `ras_err` = 0.
- Stack entry contents are don't-care.

With `enable` = 0:
- `pc_addr`, the stack and the flags hold.
- `ras_err` = 0.
- `jump`, `call` and `ret` are ignored.

With `enable` = 1, priority is `ret` > `call` > `jump` > increment:
- `ret`, stack not empty: `pc_addr` ← top entry; count decrements.
- `ret`, stack empty: `pc_addr` ← `pc_addr`+1; `ras_err` pulses (underflow).
- `call`, stack not full: push `pc_addr`+1; `pc_addr` ← `jump_addr`.
- `call`, stack full: `pc_addr` ← `jump_addr`; the push is dropped, existing entries are unchanged, and `ras_err` pulses (overflow).
- `jump` only: `pc_addr` ← `jump_addr`; stack untouched.
- No request: `pc_addr` ← `pc_addr`+1.
- All increments and the pushed return value are modulo 2^ADDR_W. For ADDR_W=12, 0xFFF+1 = 0x000.
- `call` together with `jump`: treated as `call`.
- `ret` together with `call`: `ret` executes and `call` is discarded; no error.
- The stack is a strict LIFO indexed by a count register. There is no circular overwrite.

## Timing
- Single-cycle operation: the new `pc_addr` is visible immediately after the edge on which the request was sampled.
- `ras_empty` and `ras_full` are decoded from the registered count and track it with zero extra latency.
- `ras_err` is registered. It is high for exactly the one cycle after the offending edge.
- Reset mid-operation takes effect at the next edge regardless of `enable`, `call` or `ret`. Pending requests are discarded.
- Requests are level-sampled with no handshake. A request held for N enabled cycles acts N times.

## Configuration
Macro: `PC_SEQ_RAS_EN`.
- Defined: the RAS is built, and `call`/`ret` behave as described above.
- Undefined:
  - No stack storage is built.
  - `call` behaves exactly as `jump`.
  - `ret` behaves as increment.
  - `ras_empty` is tied to 1, `ras_full` to 0, `ras_err` to 0.
- Port list is identical in both builds.

## Structure
- Package `pc_pkg` holds:
  - the operation-select enum (`OP_INC`, `OP_JUMP`, `OP_CALL`, `OP_RET`, `OP_HOLD`);
  - the `pc_addr_t` typedef derived from the default width;
  - the priority-encode function mapping the inputs to an operation.
- One sub-module, `pc_ras`:
  - parameters `ADDR_W` and `RAS_DEPTH`;
  - inputs `push`, `pop`, `push_data`;
  - outputs `top`, `empty`, `full`.
- `pc_seq` owns the PC register, operation decode and `ras_err`. `pc_ras` is instantiated only under `PC_SEQ_RAS_EN`.

## Test plan
All scenarios use ADDR_W=12, RAS_DEPTH=4, RESET_ADDR=0, with `PC_SEQ_RAS_EN` defined unless stated.
- Reset, then `enable`=1 for 3 cycles → `pc_addr` goes 0x001, 0x002, 0x003; `ras_empty`=1 throughout.
- At `pc_addr`=0x002, `jump`=1 with `jump_addr`=0xAAA for 1 cycle → `pc_addr`=0xAAA, then 0xAAB. With `enable`=0 the PC holds at 0xAAB.
- At 0x010, `call` to 0x100; 3 idle cycles; `ret` → PC goes 0x100, 0x101, 0x102, 0x103, then 0x011; `ras_empty` = 0 → 1.
- 4 nested calls, then a 5th → `ras_full`=1 after the 4th; the 5th still jumps and `ras_err` pulses once. 4 `ret`s return the saved addresses in LIFO order; a 5th `ret` increments the PC and pulses `ras_err`.
- `pc_addr`=0xFFF with no request → 0x000. `call` at 0xFFF pushes 0x000. `ret`+`call` in the same cycle executes the `ret` only.
- Build without the macro: `call` to 0x200 → PC = 0x200; a following `ret` gives 0x201; flags stay `ras_empty`=1, `ras_full`=0, `ras_err`=0. Asserting `rst_n`=0 mid-sequence gives PC = 0x000 on the next edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: operation select, address type
// and the request priority encoder.
package pc_pkg;

  localparam int PC_ADDR_W_DEFAULT = 12;

  typedef logic [PC_ADDR_W_DEFAULT-1:0] pc_addr_t;

  typedef enum logic [2:0] {
    OP_INC,
    OP_JUMP,
    OP_CALL,
    OP_RET,
    OP_HOLD
  } pc_op_e;

  // ret beats call beats jump; a disabled cycle freezes everything
  function automatic pc_op_e pcDecode(input logic enable, input logic jump,
                                      input logic call, input logic ret);
    pc_op_e op;
    if (!enable)   op = OP_HOLD;
    else if (ret)  op = OP_RET;
    else if (call) op = OP_CALL;
    else if (jump) op = OP_JUMP;
    else           op = OP_INC;
    return op;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: strict LIFO indexed by a count register, no wraparound.
// Pushes into a full stack and pops from an empty one are ignored.
module pc_ras
  import pc_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] entries_q [RAS_DEPTH];

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(RAS_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (push && !full) begin
      count_q <= count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  // Entry contents are don't-care after reset, so storage carries no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < RAS_DEPTH; i++) begin
      if (push && !full && (count_q == CNT_W'(i))) begin
        entries_q[i] <= push_data;
      end
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < RAS_DEPTH; i++) begin
      if (count_q == CNT_W'(i + 1)) begin
        top = entries_q[i];
      end
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: increment, jump, call and return for instruction fetch.
// Define PC_SEQ_RAS_EN to build the return-address stack; otherwise call acts as jump.
module pc_seq
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = PC_ADDR_W_DEFAULT,
  parameter int                RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);

  pc_op_e            op;
  logic [ADDR_W-1:0] pc_q, pc_d, pcInc;

  assign op      = pcDecode(enable, jump, call, ret);
  assign pcInc   = pc_q + ADDR_W'(1);
  assign pc_addr = pc_q;

`ifdef PC_SEQ_RAS_EN
  logic              rasPush, rasPop, rasEmpty, rasFull;
  logic [ADDR_W-1:0] rasTop;
  logic              err_q, err_d;

  pc_ras #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rasPush),
    .pop      (rasPop),
    .push_data(pcInc),
    .top      (rasTop),
    .empty    (rasEmpty),
    .full     (rasFull)
  );

  assign ras_empty = rasEmpty;
  assign ras_full  = rasFull;
  assign ras_err   = err_q;
`else
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_err   = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q;
`ifdef PC_SEQ_RAS_EN
    err_d   = 1'b0;
    rasPush = 1'b0;
    rasPop  = 1'b0;
`endif
    unique case (op)
      OP_HOLD: pc_d = pc_q;
      OP_INC:  pc_d = pcInc;
      OP_JUMP: pc_d = jump_addr;
      OP_CALL: begin
        // An overflowing call still branches; only the return address is lost
        pc_d = jump_addr;
`ifdef PC_SEQ_RAS_EN
        if (rasFull) err_d = 1'b1;
        else         rasPush = 1'b1;
`endif
      end
      OP_RET: begin
`ifdef PC_SEQ_RAS_EN
        if (rasEmpty) begin
          pc_d  = pcInc;
          err_d = 1'b1;
        end else begin
          pc_d   = rasTop;
          rasPop = 1'b1;
        end
`else
        pc_d = pcInc;
`endif
      end
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_ADDR;
`ifdef PC_SEQ_RAS_EN
      err_q <= 1'b0;
`endif
    end else begin
      pc_q <= pc_d;
`ifdef PC_SEQ_RAS_EN
      err_q <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: a reference model queues the expected outputs for
// each driven cycle, and they are popped and compared one cycle later.
module tb_pc_seq;

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [11:0] pc;
    logic        empty;
    logic        full;
    logic        err;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        jump = 1'b0;
  logic [11:0] jump_addr = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [11:0] pc_addr;
  logic        ras_empty, ras_full, ras_err;

  int          checks = 0;
  int          errors = 0;
  expect_t     scoreboard[$];
  logic [11:0] modelPc = '0;
  logic [11:0] modelStack[$];

  pc_seq #(
    .ADDR_W    (12),
    .RAS_DEPTH (DEPTH),
    .RESET_ADDR(12'h000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .jump     (jump),
    .jump_addr(jump_addr),
    .call     (call),
    .ret      (ret),
    .pc_addr  (pc_addr),
    .ras_empty(ras_empty),
    .ras_full (ras_full),
    .ras_err  (ras_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle, predict the post-edge state, and compare after the edge
  task automatic applyStimulus(input logic rstnV, input logic enV, input logic jV,
                               input logic [11:0] jaV, input logic cV,
                               input logic rV, input string tag);
    expect_t e;
    logic    err;
    rst_n = rstnV; enable = enV; jump = jV; jump_addr = jaV; call = cV; ret = rV;
    err = 1'b0;
    if (!rstnV) begin
      modelPc = 12'h000;
      modelStack.delete();
    end else if (enV) begin
      if (rV) begin
        if (RAS_EN && modelStack.size() > 0) modelPc = modelStack.pop_back();
        else begin
          modelPc = modelPc + 12'h001;
          err = RAS_EN;
        end
      end else if (cV) begin
        if (RAS_EN) begin
          if (modelStack.size() < DEPTH) modelStack.push_back(modelPc + 12'h001);
          else err = 1'b1;
        end
        modelPc = jaV;
      end else if (jV) begin
        modelPc = jaV;
      end else begin
        modelPc = modelPc + 12'h001;
      end
    end
    e.pc    = modelPc;
    e.empty = !RAS_EN || (modelStack.size() == 0);
    e.full  = RAS_EN && (modelStack.size() == DEPTH);
    e.err   = err;
    scoreboard.push_back(e);

    @(posedge clk);
    #1;
    if (scoreboard.size() == 0) begin
      checkOutput({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = scoreboard.pop_front();
      checkOutput({tag, ".pc"}, 32'(pc_addr), 32'(e.pc));
      checkOutput({tag, ".empty"}, 32'(ras_empty), 32'(e.empty));
      checkOutput({tag, ".full"}, 32'(ras_full), 32'(e.full));
      checkOutput({tag, ".err"}, 32'(ras_err), 32'(e.err));
    end
  endtask

  initial begin
    $display("[TB] start, RAS build = %0d", RAS_EN);
    applyStimulus(0, 0, 0, 12'h000, 0, 0, "reset");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 12'h000, 0, 0, "inc");

    applyStimulus(0, 1, 0, 12'h000, 0, 0, "reset2");
    applyStimulus(1, 1, 0, 12'h000, 0, 0, "inc1");
    applyStimulus(1, 1, 0, 12'h000, 0, 0, "inc2");
    applyStimulus(1, 1, 1, 12'hAAA, 0, 0, "jump");
    applyStimulus(1, 1, 0, 12'h000, 0, 0, "afterJump");
    applyStimulus(1, 0, 1, 12'h555, 1, 1, "hold1");
    applyStimulus(1, 0, 0, 12'h000, 0, 0, "hold2");

    applyStimulus(1, 1, 1, 12'h00F, 0, 0, "jumpF");
    applyStimulus(1, 1, 0, 12'h000, 0, 0, "to010");
    applyStimulus(1, 1, 1, 12'h100, 1, 0, "call100");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 12'h000, 0, 0, "idle");
    applyStimulus(1, 1, 0, 12'h000, 0, 1, "ret011");

    for (int i = 0; i < 5; i++)
      applyStimulus(1, 1, 0, 12'((i + 2) * 12'h100), 1, 0, $sformatf("nest%0d", i));
    applyStimulus(1, 0, 0, 12'h000, 0, 0, "errGone");
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 1, 0, 12'h000, 0, 1, $sformatf("unwind%0d", i));
    applyStimulus(1, 1, 0, 12'h000, 0, 0, "errClear");

    applyStimulus(1, 1, 1, 12'hFFE, 0, 0, "jumpFFE");
    applyStimulus(1, 1, 0, 12'h000, 0, 0, "toFFF");
    applyStimulus(1, 1, 0, 12'h000, 0, 0, "wrap");
    applyStimulus(1, 1, 1, 12'hFFF, 0, 0, "jumpFFF");
    applyStimulus(1, 1, 0, 12'h123, 1, 0, "callWrap");
    applyStimulus(1, 1, 1, 12'h456, 1, 1, "retAndCall");
    applyStimulus(1, 1, 0, 12'h000, 0, 1, "retEmpty");

    applyStimulus(1, 1, 0, 12'h200, 1, 0, "call200");
    applyStimulus(1, 1, 0, 12'h000, 0, 1, "retAfter200");
    applyStimulus(1, 1, 0, 12'h300, 1, 0, "call300");
    applyStimulus(0, 1, 0, 12'h400, 1, 1, "midReset");
    applyStimulus(1, 1, 0, 12'h000, 0, 0, "postReset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
